bus_load_unit: RTL and testbench

BUS_LOAD_UNIT -- requirements
Module: bus_load_unit

---
 rtl/bus_load_unit.sv | 136 +++++++++++++
 tb/tb_bus_load_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bus_load_unit.sv
// Bus-load register bank: latches the shared bus into the register addressed by writeSel,
// with a registered data-memory write strobe. Optional macro REG_INC_EN adds RC/RP/RQ increment and acZero.
module bus_load_unit #(
  parameter int WIDTH    = 12,
  parameter int IR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [WIDTH-1:0]    busIn,
  input  logic [3:0]          writeSel,
  input  logic                writeValid,
`ifdef REG_INC_EN
  input  logic                incRC,
  input  logic                incRP,
  input  logic                incRQ,
  output logic                acZero,
`endif
  output logic [WIDTH-1:0]    R,
  output logic [WIDTH-1:0]    RL,
  output logic [WIDTH-1:0]    RC,
  output logic [WIDTH-1:0]    RP,
  output logic [WIDTH-1:0]    RQ,
  output logic [WIDTH-1:0]    R1,
  output logic [WIDTH-1:0]    AC,
  output logic [IR_WIDTH-1:0] IR,
  output logic [WIDTH-1:0]    dMemData,
  output logic                dMemWrEn,
  output logic                selErr
);

  typedef enum logic [3:0] {
    SEL_DMEM = 4'd0,
    SEL_R    = 4'd1,
    SEL_IR   = 4'd2,
    SEL_RL   = 4'd3,
    SEL_RC   = 4'd4,
    SEL_RP   = 4'd5,
    SEL_RQ   = 4'd6,
    SEL_R1   = 4'd7,
    SEL_AC   = 4'd8,
    SEL_IDLE = 4'd9
  } sel_e;

  logic [WIDTH-1:0]    r_q, r_d, rl_q, rl_d, rc_q, rc_d, rp_q, rp_d;
  logic [WIDTH-1:0]    rq_q, rq_d, r1_q, r1_d, ac_q, ac_d, dd_q, dd_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                we_q, we_d, err_q, err_d;
  logic                inc_rc, inc_rp, inc_rq;

`ifdef REG_INC_EN
  assign inc_rc = incRC;
  assign inc_rp = incRP;
  assign inc_rq = incRQ;
  assign acZero = (ac_q == '0);
`else
  assign inc_rc = 1'b0;
  assign inc_rp = 1'b0;
  assign inc_rq = 1'b0;
`endif

  always_comb begin
    r_d   = r_q;
    rl_d  = rl_q;
    rp_d  = rp_q;
    rq_d  = rq_q;
    r1_d  = r1_q;
    ac_d  = ac_q;
    ir_d  = ir_q;
    dd_d  = dd_q;
    we_d  = 1'b0;
    err_d = err_q;
    // Increments go first so that a same-cycle bus load to that register overrides them.
    rc_d  = inc_rc ? rc_q + WIDTH'(1) : rc_q;
    rp_d  = inc_rp ? rp_q + WIDTH'(1) : rp_q;
    rq_d  = inc_rq ? rq_q + WIDTH'(1) : rq_q;
    if (writeValid) begin
      case (writeSel)
        SEL_DMEM: begin
          dd_d = busIn;
          we_d = 1'b1;
        end
        SEL_R:    r_d  = busIn;
        SEL_IR:   ir_d = busIn[IR_WIDTH-1:0];
        SEL_RL:   rl_d = busIn;
        SEL_RC:   rc_d = busIn;
        SEL_RP:   rp_d = busIn;
        SEL_RQ:   rq_d = busIn;
        SEL_R1:   r1_d = busIn;
        SEL_AC:   ac_d = busIn;
        SEL_IDLE: ;
        default:  err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_q   <= '0;
      rl_q  <= '0;
      rc_q  <= '0;
      rp_q  <= '0;
      rq_q  <= '0;
      r1_q  <= '0;
      ac_q  <= '0;
      ir_q  <= '0;
      dd_q  <= '0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      rl_q  <= rl_d;
      rc_q  <= rc_d;
      rp_q  <= rp_d;
      rq_q  <= rq_d;
      r1_q  <= r1_d;
      ac_q  <= ac_d;
      ir_q  <= ir_d;
      dd_q  <= dd_d;
      we_q  <= we_d;
      err_q <= err_d;
    end
  end

  assign R        = r_q;
  assign RL       = rl_q;
  assign RC       = rc_q;
  assign RP       = rp_q;
  assign RQ       = rq_q;
  assign R1       = r1_q;
  assign AC       = ac_q;
  assign IR       = ir_q;
  assign dMemData = dd_q;
  assign dMemWrEn = we_q;
  assign selErr   = err_q;

endmodule

// File: tb/tb_bus_load_unit.sv
// Bench for bus_load_unit: directed scenarios plus randomized traffic against an array-based reference model.
// Increment/acZero checks compile only when REG_INC_EN is defined.
module tb_bus_load_unit;
  localparam int W  = 12;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [W-1:0]  busIn = '0;
  logic [3:0]    writeSel = 4'd9;
  logic          writeValid = 1'b0;
  logic          incRC = 1'b0, incRP = 1'b0, incRQ = 1'b0;
  logic [W-1:0]  R, RL, RC, RP, RQ, R1, AC, dMemData;
  logic [IW-1:0] IR;
  logic          dMemWrEn, selErr;
`ifdef REG_INC_EN
  logic          acZero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference: m[code] holds register contents keyed by its writeSel code (1..8).
  logic [W-1:0] m [1:8];
  logic [W-1:0] m_dd;
  logic         m_we, m_err;

  bus_load_unit #(.WIDTH(W), .IR_WIDTH(IW)) dut (
    .clk(clk), .rstN(rstN), .busIn(busIn), .writeSel(writeSel), .writeValid(writeValid),
`ifdef REG_INC_EN
    .incRC(incRC), .incRP(incRP), .incRQ(incRQ), .acZero(acZero),
`endif
    .R(R), .RL(RL), .RC(RC), .RP(RP), .RQ(RQ), .R1(R1), .AC(AC), .IR(IR),
    .dMemData(dMemData), .dMemWrEn(dMemWrEn), .selErr(selErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 1; k <= 8; k++) m[k] = '0;
    m_dd = '0;
    m_we = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic wv, input logic [3:0] sel, input logic [W-1:0] bus,
                            input logic ic, input logic ip, input logic iq);
    logic [W-1:0] nx [1:8];
    for (int k = 1; k <= 8; k++) nx[k] = m[k];
    if (ic) nx[4] = m[4] + 1'b1;
    if (ip) nx[5] = m[5] + 1'b1;
    if (iq) nx[6] = m[6] + 1'b1;
    m_we = 1'b0;
    if (wv) begin
      if (sel == 0) begin
        m_dd = bus;
        m_we = 1'b1;
      end else if (sel == 2) nx[2] = bus % (1 << IW);
      else if (sel <= 8) nx[sel] = bus;
      else if (sel >= 10) m_err = 1'b1;
    end
    for (int k = 1; k <= 8; k++) m[k] = nx[k];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".R"},  32'(R),  32'(m[1]));
    chk({tag, ".IR"}, 32'(IR), 32'(m[2]));
    chk({tag, ".RL"}, 32'(RL), 32'(m[3]));
    chk({tag, ".RC"}, 32'(RC), 32'(m[4]));
    chk({tag, ".RP"}, 32'(RP), 32'(m[5]));
    chk({tag, ".RQ"}, 32'(RQ), 32'(m[6]));
    chk({tag, ".R1"}, 32'(R1), 32'(m[7]));
    chk({tag, ".AC"}, 32'(AC), 32'(m[8]));
    chk({tag, ".dd"}, 32'(dMemData), 32'(m_dd));
    chk({tag, ".we"}, 32'(dMemWrEn), 32'(m_we));
    chk({tag, ".err"}, 32'(selErr), 32'(m_err));
`ifdef REG_INC_EN
    chk({tag, ".acz"}, 32'(acZero), 32'(m[8] == 0));
`endif
  endtask

  // Drive one cycle's inputs, take the edge, advance the model, check 1 ns later.
  task automatic cyc(input logic wv, input logic [3:0] sel, input logic [W-1:0] bus,
                     input logic ic = 1'b0, input logic ip = 1'b0, input logic iq = 1'b0);
    logic eic, eip, eiq;
    writeValid = wv;
    writeSel   = sel;
    busIn      = bus;
`ifdef REG_INC_EN
    incRC = ic; incRP = ip; incRQ = iq;
    eic = ic; eip = ip; eiq = iq;
`else
    eic = 1'b0; eip = 1'b0; eiq = 1'b0;
`endif
    @(posedge clk);
    model_step(wv, sel, bus, eic, eip, eiq);
    #1;
    check_all("cyc");
  endtask

  // Reset pulse landing between edges; outputs must clear before the next edge.
  task automatic mid_reset();
    #3;
    rstN = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    #2;
    rstN = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("rst");
    #20;
    rstN = 1'b1;

    for (int k = 1; k <= 8; k++) cyc(1'b1, 4'(k), W'(10 + k));
    chk("seq.R", 32'(R), 11);
    chk("seq.IR", 32'(IR), 12);
    chk("seq.RL", 32'(RL), 13);
    chk("seq.RC", 32'(RC), 14);
    chk("seq.RP", 32'(RP), 15);
    chk("seq.RQ", 32'(RQ), 16);
    chk("seq.R1", 32'(R1), 17);
    chk("seq.AC", 32'(AC), 18);
    chk("seq.we", 32'(dMemWrEn), 0);

    cyc(1'b1, 4'd0, W'(10));
    chk("dm1.we", 32'(dMemWrEn), 1);
    cyc(1'b1, 4'd0, W'(10));
    chk("dm2.we", 32'(dMemWrEn), 1);
    cyc(1'b0, 4'd0, W'(77));
    chk("dm3.we", 32'(dMemWrEn), 0);
    chk("dm3.dd", 32'(dMemData), 10);

    cyc(1'b1, 4'd2, 12'hABC);
    chk("ir.trunc", 32'(IR), 32'h0BC);

    cyc(1'b1, 4'd4, 12'hFFF);
    cyc(1'b1, 4'd5, W'(5));
`ifdef REG_INC_EN
    cyc(1'b0, 4'd9, '0, 1'b1, 1'b0, 1'b0);
    chk("rc.wrap", 32'(RC), 0);
    cyc(1'b1, 4'd5, W'(9), 1'b0, 1'b1, 1'b0);
    chk("rp.loadwins", 32'(RP), 9);
    cyc(1'b1, 4'd8, W'(0));
    chk("acz.one", 32'(acZero), 1);
    cyc(1'b1, 4'd8, W'(3));
    chk("acz.zero", 32'(acZero), 0);
`endif

    cyc(1'b1, 4'd12, W'(12'h555));
    chk("err.set", 32'(selErr), 1);
    cyc(1'b0, 4'd9, '0);
    chk("err.hold", 32'(selErr), 1);
    mid_reset();
    chk("err.clr", 32'(selErr), 0);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      cyc(1'($urandom_range(0, 3) != 0), s, W'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 60) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
